// File: rtl/ram_sp_param.sv
// Parametrised single-port synchronous RAM with a configurable read-during-write policy,
// optional output register and an optional post-reset clear engine.
// The read-data port is named dout because `do` is a reserved word in SystemVerilog.
module ram_sp_param #(
   parameter int unsigned DATA_W       = 4,
   parameter int unsigned ADDR_W       = 5,
   parameter int unsigned DEPTH        = 32,
   parameter int unsigned RDW_MODE     = 1,
   parameter int unsigned OUT_REG      = 0,
   parameter int unsigned CLEAR_ON_RST = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] a,
   input  logic [DATA_W-1:0] di,
   output logic [DATA_W-1:0] dout,
   output logic              rd_valid,
   output logic              busy
);

   localparam logic [ADDR_W:0]   DepthW   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

   typedef enum logic [0:0] {StClear, StIdle} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              clr_en;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              acc, in_range;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rd_take;
   logic [DATA_W-1:0] rd_data;

   // Pipeline: s0 captures at the accepting edge, s1 is the unregistered-output stage,
   // s2 is the optional extra output register.
   logic              s0_v, s1_v, s2_v;
   logic [DATA_W-1:0] s0_d, s1_d, s2_d;

   assign busy     = (state_q == StClear);
   assign acc      = en & ~busy & ~rst;
   assign in_range = ({1'b0, a} < DepthW);

   // Clear engine next-state: walk cnt from 0 to DEPTH-1, then settle in idle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr_en  = 1'b0;
      if (state_q == StClear) begin
         clr_en = 1'b1;
         cnt_d  = cnt_q + 1'b1;
         if (cnt_q == LastAddr) begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      end
   end

   // State and clear-counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= (CLEAR_ON_RST != 0) ? StClear : StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Single write port shared by the clear engine and accepted in-range writes.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = a;
      wr_data = di;
      if (!rst) begin
         if (clr_en) begin
            wr_en   = 1'b1;
            wr_addr = cnt_q;
            wr_data = '0;
         end else if (acc && we && in_range) begin
            wr_en = 1'b1;
         end
      end
   end

   // Memory array; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Decide whether this access returns data and which value it returns.
   always_comb begin
      rd_take = 1'b0;
      rd_data = '0;
      if (acc) begin
         if (!we || RDW_MODE == 0) begin
            // Plain read or read-first write: old contents, zero when out of range.
            rd_take = 1'b1;
            rd_data = in_range ? mem[a] : '0;
         end else if (RDW_MODE == 1) begin
            rd_take = 1'b1;
            rd_data = di;
         end
      end
   end

   // Read pipeline; data stages only load with valid so dout holds between reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         s0_v <= 1'b0;
         s1_v <= 1'b0;
         s2_v <= 1'b0;
         s0_d <= '0;
         s1_d <= '0;
         s2_d <= '0;
      end else begin
         s0_v <= rd_take;
         s1_v <= s0_v;
         s2_v <= s1_v;
         if (rd_take) s0_d <= rd_data;
         if (s0_v)    s1_d <= s0_d;
         if (s1_v)    s2_d <= s1_d;
      end
   end

   assign dout     = (OUT_REG != 0) ? s2_d : s1_d;
   assign rd_valid = (OUT_REG != 0) ? s2_v : s1_v;

endmodule
